vector_mem_ctrl: RTL and testbench

VECTOR_MEM_CTRL -- requirements
Module: vector_mem_ctrl

---
 rtl/vmem_pkg.sv | 20 ++
 rtl/vmem_array.sv | 28 ++
 rtl/vector_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_vector_mem_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory controller.
package vmem_pkg;

    localparam int ADDR_W        = 16;
    localparam int LANES_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD1  = 2'd2,
        ST_RD2  = 2'd3
    } vmem_state_e;

    // Addresses are never folded modulo depth, so the full 16 bits are compared.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [31:0]       depth);
        return ({16'h0000, addr} < depth);
    endfunction

endpackage

// File: rtl/vmem_array.sv
// DEPTH x W storage: one synchronous write port, one registered read port, no reset.
module vmem_array #(
    parameter int DEPTH = 1024,
    parameter int W     = 512,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];
    logic [W-1:0] rdata_r;

    // Write port and registered read port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/vector_mem_ctrl.sv
// Vector memory controller: serialises processing-block reads/writes and host preloads
// onto a single-ported array, with a fixed two-cycle read pipeline.
module vector_mem_ctrl
    import vmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int LANES = LANES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_ctrl,
    input  logic [ADDR_W-1:0]     load_addr,
    output logic [16*LANES-1:0]   load_data,
    output logic                  load_valid,
    input  logic                  write_ctrl,
    input  logic [ADDR_W-1:0]     write_addr,
    input  logic [16*LANES-1:0]   write_data,
    output logic                  write_done,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [16*LANES-1:0]   host_wdata,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int W     = 16 * LANES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    vmem_state_e      state_r;
    logic [W-1:0]     load_data_r;
    logic             load_valid_r;
    logic             write_done_r;
    logic             busy_r;
    logic             addr_err_r;
    logic             rd_oor_r;

    logic             wr_ok_s;
    logic             rd_ok_s;
    logic             host_ok_s;
    logic             arr_we_s;
    logic [IDX_W-1:0] arr_waddr_s;
    logic [W-1:0]     arr_wdata_s;
    logic [W-1:0]     arr_rdata_s;

    assign wr_ok_s   = addr_in_range(write_addr, 32'(DEPTH));
    assign rd_ok_s   = addr_in_range(load_addr,  32'(DEPTH));
    assign host_ok_s = addr_in_range(host_addr,  32'(DEPTH));

    // Array write arbitration: processing-block write wins, host only when both ctrl are low.
    always_comb begin
        arr_we_s    = 1'b0;
        arr_waddr_s = write_addr[IDX_W-1:0];
        arr_wdata_s = write_data;
        if (reset_n && (state_r == ST_IDLE)) begin
            if (write_ctrl) begin
                arr_we_s = wr_ok_s;
            end else if (!load_ctrl && host_we) begin
                arr_we_s    = host_ok_s;
                arr_waddr_s = host_addr[IDX_W-1:0];
                arr_wdata_s = host_wdata;
            end else begin
                arr_we_s = 1'b0;
            end
        end else begin
            arr_we_s = 1'b0;
        end
    end

    // The read port is addressed straight from load_addr so data is captured on the accepting edge.
    vmem_array #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we_s),
        .waddr (arr_waddr_s),
        .wdata (arr_wdata_s),
        .raddr (load_addr[IDX_W-1:0]),
        .rdata (arr_rdata_s)
    );

    // Control FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            load_data_r  <= '0;
            load_valid_r <= 1'b0;
            write_done_r <= 1'b0;
            busy_r       <= 1'b0;
            addr_err_r   <= 1'b0;
            rd_oor_r     <= 1'b0;
        end else begin
            load_valid_r <= 1'b0;
            write_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (write_ctrl) begin
                        state_r      <= ST_WR;
                        write_done_r <= 1'b1;
                        busy_r       <= 1'b1;
                        addr_err_r   <= addr_err_r | ~wr_ok_s;
                    end else if (load_ctrl) begin
                        state_r    <= ST_RD1;
                        busy_r     <= 1'b1;
                        rd_oor_r   <= ~rd_ok_s;
                        addr_err_r <= addr_err_r | ~rd_ok_s;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (load_ctrl) begin
                        state_r    <= ST_RD1;
                        busy_r     <= 1'b1;
                        rd_oor_r   <= ~rd_ok_s;
                        addr_err_r <= addr_err_r | ~rd_ok_s;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RD1: begin
                    state_r      <= ST_RD2;
                    load_valid_r <= 1'b1;
                    load_data_r  <= rd_oor_r ? '0 : arr_rdata_s;
                end
                ST_RD2: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign load_data  = load_data_r;
    assign load_valid = load_valid_r;
    assign write_done = write_done_r;
    assign busy       = busy_r;
    assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_vector_mem_ctrl.sv
// Self-checking bench for vector_mem_ctrl: vector table plus hand-written corner sequences.
module tb_vector_mem_ctrl;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         load_ctrl;
    logic [15:0]  load_addr;
    logic [511:0] load_data;
    logic         load_valid;
    logic         write_ctrl;
    logic [15:0]  write_addr;
    logic [511:0] write_data;
    logic         write_done;
    logic         host_we;
    logic [15:0]  host_addr;
    logic [511:0] host_wdata;
    logic         busy;
    logic         addr_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [511:0] exp_q[$];

    typedef struct {
        logic         is_wr;
        logic [15:0]  addr;
        logic [511:0] data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[13];

    vector_mem_ctrl #(.DEPTH(1024), .LANES(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_ctrl  (load_ctrl),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_valid (load_valid),
        .write_ctrl (write_ctrl),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_done (write_done),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .busy       (busy),
        .addr_err   (addr_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: run did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    function automatic logic [511:0] rep(input logic [15:0] v);
        return {32{v}};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every load_valid must match the oldest expected read.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && load_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_load_valid: got 1 required 0");
            end else begin
                check("load_data", load_data, exp_q.pop_front());
            end
        end
    end

    task automatic host_write(input logic [15:0] a, input logic [511:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        check("host_no_write_done", {511'd0, write_done}, 512'd0);
        host_we = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [511:0] d);
        write_ctrl = 1'b1; write_addr = a; write_data = d;
        tick();
        check("write_done_pulse", {511'd0, write_done}, 512'd1);
        write_ctrl = 1'b0;
        tick();
        check("write_done_clear", {510'd0, write_done, busy}, 512'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [511:0] exp);
        exp_q.push_back(exp);
        load_ctrl = 1'b1; load_addr = a;
        tick();
        check("rd1_no_valid", {510'd0, load_valid, busy}, 512'd1);
        tick();
        check("rd2_valid", {511'd0, load_valid}, 512'd1);
        load_ctrl = 1'b0;
        tick();
        check("rd_idle", {510'd0, load_valid, busy}, 512'd0);
    endtask

    initial begin
        reset_n = 1'b0; load_ctrl = 1'b0; load_addr = 16'd0;
        write_ctrl = 1'b0; write_addr = 16'd0; write_data = 512'd0;
        host_we = 1'b0; host_addr = 16'd0; host_wdata = 512'd0;

        vecs[0]  = '{1'b1, 16'd7,     rep(16'ha5a5), 1'b0};
        vecs[1]  = '{1'b1, 16'd8,     rep(16'h5a01), 1'b0};
        vecs[2]  = '{1'b0, 16'd7,     rep(16'ha5a5), 1'b0};
        vecs[3]  = '{1'b0, 16'd8,     rep(16'h5a01), 1'b0};
        vecs[4]  = '{1'b1, 16'd7,     rep(16'hc3c3), 1'b0};
        vecs[5]  = '{1'b0, 16'd7,     rep(16'hc3c3), 1'b0};
        vecs[6]  = '{1'b1, 16'd1023,  rep(16'h7e57), 1'b0};
        vecs[7]  = '{1'b0, 16'd1023,  rep(16'h7e57), 1'b0};
        vecs[8]  = '{1'b0, 16'd1024,  512'd0,        1'b1};
        vecs[9]  = '{1'b1, 16'd1024,  rep(16'hdead), 1'b1};
        vecs[10] = '{1'b0, 16'd0,     rep(16'h3e4d), 1'b1};
        vecs[11] = '{1'b0, 16'd65535, 512'd0,        1'b1};
        vecs[12] = '{1'b0, 16'd8,     rep(16'h5a01), 1'b1};

        tick();
        tick();
        check("reset_outputs", {508'd0, load_valid, write_done, busy, addr_err}, 512'd0);
        check("reset_load_data", load_data, 512'd0);
        reset_n = 1'b1;
        tick();

        // Preload and basic read/write round trips.
        host_write(16'd0, rep(16'h3e4d));
        host_write(16'd1, rep(16'h4000));
        do_read(16'd0, rep(16'h3e4d));
        do_write(16'd3, rep(16'h3f1a));
        do_read(16'd3, rep(16'h3f1a));

        // Simultaneous write and read of the same address: write first, read sees new data.
        exp_q.push_back(rep(16'h1234));
        write_ctrl = 1'b1; load_ctrl = 1'b1;
        write_addr = 16'd5; load_addr = 16'd5; write_data = rep(16'h1234);
        tick();
        check("both_wr_done", {510'd0, write_done, load_valid}, 512'd2);
        write_ctrl = 1'b0;
        tick();
        check("both_rd1", {510'd0, write_done, load_valid}, 512'd0);
        tick();
        check("both_valid_at_3", {511'd0, load_valid}, 512'd1);
        load_ctrl = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data);
            end else begin
                do_read(vecs[i].addr, vecs[i].data);
            end
            check("addr_err", {511'd0, addr_err}, {511'd0, vecs[i].exp_err});
        end

        tick();
        tick();
        check("load_data_hold", load_data, rep(16'h5a01));

        // Host writes while a request is pending or the FSM is busy are ignored.
        exp_q.push_back(rep(16'h0909));
        host_we = 1'b1; host_addr = 16'd0; host_wdata = rep(16'hffff);
        write_ctrl = 1'b1; load_ctrl = 1'b1;
        write_addr = 16'd9; load_addr = 16'd9; write_data = rep(16'h0909);
        tick();
        write_ctrl = 1'b0;
        tick();
        tick();
        load_ctrl = 1'b0; host_we = 1'b0;
        tick();
        do_read(16'd0, rep(16'h3e4d));

        // Reset during RD1 abandons the read.
        load_ctrl = 1'b1; load_addr = 16'd0;
        tick();
        check("rd1_busy_before_reset", {511'd0, busy}, 512'd1);
        reset_n = 1'b0; load_ctrl = 1'b0;
        tick();
        check("mid_reset_outputs", {508'd0, load_valid, write_done, busy, addr_err}, 512'd0);
        check("mid_reset_load_data", load_data, 512'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_no_valid", {511'd0, load_valid}, 512'd0);
        do_read(16'd1, rep(16'h4000));
        do_read(16'd3, rep(16'h3f1a));

        tick();
        tick();
        check("scoreboard_drained", 512'(exp_q.size()), 512'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
